// File: rtl/turbo_frame_encoder.sv
// turbo_frame_encoder
//   Rate-1/3 turbo encoder. Buffers one frame of INPUT_SIZE information bits,
//   then emits EXTEND_SIZE symbols (information plus two zero tail steps).
//   Each symbol carries the systematic bit and two parities, as hard bits and
//   as antipodal soft values (+AMP for 1, -AMP for 0).
//   Encoder 1 sees the natural bit order. Encoder 2 sees bit pi(k) = (IL_A*k) mod INPUT_SIZE.
//
// Ports
//   clk_i, reset_n_i          clock (rising edge), async active-low reset
//   in_valid_i, in_bit_i      serial information bits, frame index 0 first
//   in_ready_o                high while a frame is being loaded
//   out_valid_o, out_ready_i  output symbol handshake
//   sys_bit_o, par1_bit_o, par2_bit_o   hard symbol bits
//   sys_o, par1_o, par2_o     signed soft values, SOFT_W bits
//   out_idx_o, out_last_o     symbol index, and a flag for the final symbol
//   frame_done_o              one-cycle pulse after the last symbol handshake
//
// state     | meaning
// ST_LOAD   | accepting information bits into the frame buffer
// ST_ENCODE | presenting symbols 0..EXTEND_SIZE-1, advancing on each handshake
module turbo_frame_encoder #(
  parameter int INPUT_SIZE  = 5,
  parameter int EXTEND_SIZE = 7,
  parameter int SOFT_W      = 7,
  parameter int AMP         = 4,
  parameter int IL_A        = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             in_valid_i,
  input  logic                             in_bit_i,
  output logic                             in_ready_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             sys_bit_o,
  output logic                             par1_bit_o,
  output logic                             par2_bit_o,
  output logic signed [SOFT_W-1:0]         sys_o,
  output logic signed [SOFT_W-1:0]         par1_o,
  output logic signed [SOFT_W-1:0]         par2_o,
  output logic [$clog2(EXTEND_SIZE)-1:0]   out_idx_o,
  output logic                             out_last_o,
  output logic                             frame_done_o
);

  localparam int CNT_W = $clog2(INPUT_SIZE);
  localparam int IDX_W = $clog2(EXTEND_SIZE);

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(INPUT_SIZE - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(EXTEND_SIZE - 1);
  localparam logic [IDX_W-1:0]         IDX_INFO = IDX_W'(INPUT_SIZE);
  localparam logic [CNT_W:0]           PI_STEP  = (CNT_W + 1)'(IL_A);
  localparam logic [CNT_W:0]           PI_MOD   = (CNT_W + 1)'(INPUT_SIZE);
  localparam logic signed [SOFT_W-1:0] SOFT_POS = SOFT_W'(AMP);
  localparam logic signed [SOFT_W-1:0] SOFT_NEG = SOFT_W'(-AMP);

  typedef enum logic {ST_LOAD, ST_ENCODE} state_t;

  state_t state_q, state_d;

  logic [INPUT_SIZE-1:0]    info_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         pi_q, pi_d;
  logic [CNT_W:0]           pi_sum;
  // Encoder states {d1,d2} in effect for the symbol currently presented.
  logic [1:0]               s1_q, s1_d, s2_q, s2_d;
  logic                     u2_q;
  logic                     sys_q, p1_q, p2_q, last_q, valid_q, done_q;
  logic signed [SOFT_W-1:0] sys_soft_q, p1_soft_q, p2_soft_q;
  logic                     wr_en, load_sym, clear_out, done_d;
  logic                     in_info, u1, u2;

  function automatic logic signed [SOFT_W-1:0] soft_of(input logic b);
    return b ? SOFT_POS : SOFT_NEG;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_LOAD;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pi_d      = pi_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    wr_en     = 1'b0;
    load_sym  = 1'b0;
    clear_out = 1'b0;
    done_d    = 1'b0;

    // Interleaver address for the next symbol: modular accumulate, no multiply.
    pi_sum = {1'b0, pi_q} + PI_STEP;
    if (pi_sum >= PI_MOD) pi_sum = pi_sum - PI_MOD;

    case (state_q)
      ST_LOAD: begin
        if (in_valid_i) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Symbol 0 only needs bit 0, which is already buffered.
            state_d  = ST_ENCODE;
            cnt_d    = '0;
            load_sym = 1'b1;
            idx_d    = '0;
            pi_d     = '0;
            s1_d     = '0;
            s2_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ENCODE: begin
        if (valid_q && out_ready_i) begin
          if (last_q) begin
            state_d   = ST_LOAD;
            clear_out = 1'b1;
            done_d    = 1'b1;
            idx_d     = '0;
            pi_d      = '0;
            s1_d      = '0;
            s2_d      = '0;
          end else begin
            load_sym = 1'b1;
            idx_d    = idx_q + 1'b1;
            pi_d     = pi_sum[CNT_W-1:0];
            s1_d     = {sys_q, s1_q[1]};
            s2_d     = {u2_q, s2_q[1]};
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Tail steps feed zeros into both encoders.
    in_info = (idx_d < IDX_INFO);
    u1      = in_info ? info_q[idx_d[CNT_W-1:0]] : 1'b0;
    u2      = in_info ? info_q[pi_d] : 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      info_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      pi_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      u2_q       <= 1'b0;
      sys_q      <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      sys_soft_q <= '0;
      p1_soft_q  <= '0;
      p2_soft_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pi_q   <= pi_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      done_q <= done_d;
      if (wr_en) info_q[cnt_q] <= in_bit_i;
      if (load_sym) begin
        valid_q    <= 1'b1;
        u2_q       <= u2;
        sys_q      <= u1;
        p1_q       <= u1 ^ s1_d[0];
        p2_q       <= u2 ^ s2_d[0];
        last_q     <= (idx_d == IDX_LAST);
        sys_soft_q <= soft_of(u1);
        p1_soft_q  <= soft_of(u1 ^ s1_d[0]);
        p2_soft_q  <= soft_of(u2 ^ s2_d[0]);
      end else if (clear_out) begin
        valid_q    <= 1'b0;
        u2_q       <= 1'b0;
        sys_q      <= 1'b0;
        p1_q       <= 1'b0;
        p2_q       <= 1'b0;
        last_q     <= 1'b0;
        sys_soft_q <= '0;
        p1_soft_q  <= '0;
        p2_soft_q  <= '0;
      end
    end
  end

  assign in_ready_o   = (state_q == ST_LOAD);
  assign out_valid_o  = valid_q;
  assign sys_bit_o    = sys_q;
  assign par1_bit_o   = p1_q;
  assign par2_bit_o   = p2_q;
  assign sys_o        = sys_soft_q;
  assign par1_o       = p1_soft_q;
  assign par2_o       = p2_soft_q;
  assign out_idx_o    = idx_q;
  assign out_last_o   = last_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_turbo_frame_encoder.sv
module tb_turbo_frame_encoder;

  localparam int N   = 5;
  localparam int E   = 7;
  localparam int AMP = 4;
  localparam int ILA = 2;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              in_valid_i, in_bit_i, in_ready_o;
  logic              out_valid_o, out_ready_i;
  logic              sys_bit_o, par1_bit_o, par2_bit_o;
  logic signed [6:0] sys_o, par1_o, par2_o;
  logic [2:0]        out_idx_o;
  logic              out_last_o, frame_done_o;

  turbo_frame_encoder #(
    .INPUT_SIZE(N), .EXTEND_SIZE(E), .SOFT_W(7), .AMP(AMP), .IL_A(ILA)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .in_valid_i(in_valid_i), .in_bit_i(in_bit_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sys_bit_o(sys_bit_o), .par1_bit_o(par1_bit_o), .par2_bit_o(par2_bit_o),
    .sys_o(sys_o), .par1_o(par1_o), .par2_o(par2_o),
    .out_idx_o(out_idx_o), .out_last_o(out_last_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int got_ss[E];
  int got_s1[E];
  int got_s2[E];

  always @(negedge clk_i) if (frame_done_o === 1'b1) done_cnt++;

  typedef struct {
    logic [0:N-1] bits;
    int           mode;   // 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    logic [0:E-1] sys;
    logic [0:E-1] par1;
    logic [0:E-1] par2;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: each parity is u[k] ^ u[k-2] of its encoder's input stream,
  // since the register pair is a two-step delay line that starts at zero.
  task automatic model(input logic [0:N-1] b, output logic [0:E-1] s,
                       output logic [0:E-1] p1, output logic [0:E-1] p2);
    logic [0:E-1] a1, a2;
    for (int k = 0; k < E; k++) begin
      a1[k] = (k < N) ? b[k] : 1'b0;
      a2[k] = (k < N) ? b[(ILA * k) % N] : 1'b0;
    end
    for (int k = 0; k < E; k++) begin
      s[k]  = a1[k];
      p1[k] = a1[k] ^ ((k >= 2) ? a1[k-2] : 1'b0);
      p2[k] = a2[k] ^ ((k >= 2) ? a2[k-2] : 1'b0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " in_ready"}, in_ready_o, 1);
    chk({tag, " out_valid"}, out_valid_o, 0);
    chk({tag, " outputs"}, {sys_bit_o, par1_bit_o, par2_bit_o, sys_o, par1_o, par2_o,
                            out_idx_o, out_last_o, frame_done_o}, 0);
  endtask

  task automatic send_frame(input logic [0:N-1] b);
    int w;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_bit_i   = b[i];
      w = 0;
      while (!in_ready_o && w < 50) begin
        @(negedge clk_i);
        w++;
      end
      if (!in_ready_o) chk("in_ready timeout", 0, 1);
      @(posedge clk_i);
    end
    #1 in_valid_i = 1'b0;
  endtask

  task automatic collect_frame(input int mode, output logic [0:E-1] s,
                               output logic [0:E-1] p1, output logic [0:E-1] p2);
    int   k;
    bit   fin, stalled;
    logic [27:0] held, cur;
    k = 0; fin = 0; stalled = 0; held = '0;
    s = '0; p1 = '0; p2 = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk_i);
      case (mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (cyc % 3 == 0);
        default: out_ready_i = ($urandom_range(3, 0) != 0);
      endcase
      cur = {sys_bit_o, par1_bit_o, par2_bit_o, sys_o, par1_o, par2_o, out_idx_o, out_last_o};
      if (out_valid_o) begin
        if (stalled) chk("hold during stall", cur, held);
        if (out_ready_i) begin
          if (k < E) begin
            chk("out_idx", out_idx_o, k);
            chk("out_last", out_last_o, (k == E - 1));
            chk("frame_done early", frame_done_o, 0);
            s[k] = sys_bit_o; p1[k] = par1_bit_o; p2[k] = par2_bit_o;
            got_ss[k] = int'(sys_o); got_s1[k] = int'(par1_o); got_s2[k] = int'(par2_o);
          end else begin
            chk("symbol overrun", k, E - 1);
            fin = 1;
          end
          if (out_last_o) fin = 1;
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = cur;
        end
      end
    end
    if (!fin) chk("last symbol timeout", 0, 1);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("frame_done pulse", frame_done_o, 1);
    chk("out_valid after last", out_valid_o, 0);
    chk("in_ready after last", in_ready_o, 1);
  endtask

  task automatic compare(input string tag, input logic [0:E-1] es, input logic [0:E-1] ep1,
                         input logic [0:E-1] ep2, input logic [0:E-1] gs,
                         input logic [0:E-1] g1, input logic [0:E-1] g2);
    chk({tag, " sys"}, gs, es);
    chk({tag, " par1"}, g1, ep1);
    chk({tag, " par2"}, g2, ep2);
    for (int k = 0; k < E; k++) begin
      chk({tag, " sys soft"}, got_ss[k], es[k] ? AMP : -AMP);
      chk({tag, " par1 soft"}, got_s1[k], ep1[k] ? AMP : -AMP);
      chk({tag, " par2 soft"}, got_s2[k], ep2[k] ? AMP : -AMP);
    end
  endtask

  logic [0:E-1]   gs, g1, g2, es, e1, e2, es_b, e1_b, e2_b;
  logic [0:N-1]   rb, f1, f2;
  logic [0:2*N-1] stream;
  int             drv_j, drv_guard;

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Single 1 at index 4: parity u[k]^u[k-2] puts it on symbols 4 and 6 of
    // encoder 1; encoder 2 sees it at step 2 (pi(2)=4), so symbols 2 and 4.
    vecs[0] = '{bits: 5'b10110, mode: 0, sys: 7'b1011000, par1: 7'b1001110, par2: 7'b1111101};
    vecs[1] = '{bits: 5'b00000, mode: 0, sys: 7'b0000000, par1: 7'b0000000, par2: 7'b0000000};
    vecs[2] = '{bits: 5'b10110, mode: 1, sys: 7'b1011000, par1: 7'b1001110, par2: 7'b1111101};
    vecs[3] = '{bits: 5'b00001, mode: 0, sys: 7'b0000100, par1: 7'b0000101, par2: 7'b0010100};

    in_valid_i = 1'b0; in_bit_i = 1'b0; out_ready_i = 1'b0; reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].bits);
      collect_frame(vecs[v].mode, gs, g1, g2);
      compare($sformatf("vec%0d", v), vecs[v].sys, vecs[v].par1, vecs[v].par2, gs, g1, g2);
    end

    // Back-to-back frames with in_valid_i held high; garbage is offered whenever
    // the block is not ready, so any wrongly buffered bit corrupts frame 2.
    f1 = 5'b11010;
    f2 = 5'b01101;
    stream = {f1, f2};
    model(f1, es, e1, e2);
    model(f2, es_b, e1_b, e2_b);
    drv_j = 0;
    drv_guard = 0;
    fork
      begin
        while (drv_j < 2 * N && drv_guard < 400) begin
          @(negedge clk_i);
          drv_guard++;
          in_valid_i = 1'b1;
          if (in_ready_o) begin
            in_bit_i = stream[drv_j];
            drv_j++;
          end else begin
            in_bit_i = 1'($urandom);
          end
        end
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
      end
      begin
        collect_frame(0, gs, g1, g2);
        compare("b2b frame1", es, e1, e2, gs, g1, g2);
        collect_frame(0, gs, g1, g2);
        compare("b2b frame2", es_b, e1_b, e2_b, gs, g1, g2);
      end
    join

    // Reset during ENCODE once symbols 0..3 have been taken.
    send_frame(vecs[0].bits);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("pre-reset idx", out_idx_o, 4);
    reset_n_i = 1'b0;
    #1 check_idle("mid reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    send_frame(vecs[0].bits);
    collect_frame(0, gs, g1, g2);
    compare("after reset", vecs[0].sys, vecs[0].par1, vecs[0].par2, gs, g1, g2);

    for (int r = 0; r < 6; r++) begin
      rb = 5'($urandom);
      model(rb, es, e1, e2);
      send_frame(rb);
      collect_frame(2, gs, g1, g2);
      compare($sformatf("rand%0d", r), es, e1, e2, gs, g1, g2);
    end

    @(negedge clk_i);
    chk("frame_done pulses", done_cnt, 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
